// File: rtl/dm_subsys_pkg.sv
// Shared address map, STATUS bit layout and decode helpers for the
// data-memory subsystem.
package dm_subsys_pkg;

    localparam logic [31:0] RAM_TOP       = 32'h0000_00FF;
    localparam logic [31:0] TXD           = 32'h0000_0100;
    localparam logic [31:0] STATUS        = 32'h0000_0104;
    localparam logic [31:0] CYCLE         = 32'h0000_0108;
    localparam logic [31:0] CTRL          = 32'h0000_010C;
    localparam logic [31:0] UNMAPPED_DATA = 32'hFFFF_FFFF;

    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVF       = 2;
    localparam int STATUS_COUNT_LSB = 4;
    localparam int STATUS_COUNT_W   = 5;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_TXD,
        SEL_STATUS,
        SEL_CYCLE,
        SEL_CTRL,
        SEL_NONE
    } sel_e;

    // Byte-lane bits are masked off so any byte address hits its word.
    function automatic sel_e decode(input logic [31:0] addr);
        logic [31:0] a;
        a = addr & 32'hFFFF_FFFC;
        if (a <= RAM_TOP) return SEL_RAM;
        case (a)
            TXD:     return SEL_TXD;
            STATUS:  return SEL_STATUS;
            CYCLE:   return SEL_CYCLE;
            CTRL:    return SEL_CTRL;
            default: return SEL_NONE;
        endcase
    endfunction

    function automatic logic [31:0] status_word(input logic empty,
                                                input logic full,
                                                input logic ovf,
                                                input logic [STATUS_COUNT_W-1:0] count);
        logic [31:0] s;
        s = '0;
        s[STATUS_EMPTY] = empty;
        s[STATUS_FULL]  = full;
        s[STATUS_OVF]   = ovf;
        s[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
        return s;
    endfunction

endpackage

// File: rtl/dm_subsys_tx_fifo.sv
// Synchronous byte FIFO without fall-through; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    output logic          full,
    output logic          drop,
    output logic          valid,
    input  logic          ready,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty_next
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          do_push;
    logic          do_pop;

    // Handshake: head is transferred on every edge where valid && ready;
    // valid never depends on ready, and head stays stable while valid && !ready.
    assign valid      = (cnt != '0);
    assign full       = (cnt == CW'(DEPTH));
    assign do_pop     = valid & ready;
    assign do_push    = push & (~full | do_pop);
    assign drop       = push & ~do_push;
    assign cnt_next   = cnt + CW'(do_push) - CW'(do_pop);
    assign empty_next = (cnt_next == '0);
    assign count      = cnt;
    assign head       = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/dm_subsys.sv
// Data-memory subsystem on the core's DM port: word RAM, TX FIFO window,
// STATUS/CYCLE/CTRL registers and a registered transmit-done interrupt.
module dm_subsys
    import dm_subsys_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        DM_CLK,
    input  logic        RST,
    input  logic        DM_WE,
    input  logic [31:0] DM_ADDR,
    input  logic [31:0] DM_WR_DATA,
    output logic [31:0] DM_RD_DATA,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        IRQ
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    sel_e              sel;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram [RAM_WORDS];
    logic [31:0]       cycle_cnt;
    logic              ovf;
    logic              ie;
    logic              ie_next;
    logic [31:0]       rd_next;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_drop;
    logic              fifo_empty_next;
    logic [CW-1:0]     fifo_count;

    assign sel       = decode(DM_ADDR);
    assign ram_idx   = DM_ADDR[RAM_AW+1:2];
    assign fifo_push = DM_WE && (sel == SEL_TXD);
    assign ie_next   = (DM_WE && sel == SEL_CTRL) ? DM_WR_DATA[0] : ie;

    tx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (8)
    ) u_tx_fifo (
        .clk       (DM_CLK),
        .rst       (RST),
        .push      (fifo_push),
        .push_data (DM_WR_DATA[7:0]),
        .full      (fifo_full),
        .drop      (fifo_drop),
        .valid     (TX_VALID),
        .ready     (TX_READY),
        .head      (TX_DATA),
        .count     (fifo_count),
        .empty_next(fifo_empty_next)
    );

    always_comb begin
        rd_next = UNMAPPED_DATA;
        case (sel)
            SEL_RAM:    rd_next = ram[ram_idx];
            SEL_TXD:    rd_next = '0;
            SEL_STATUS: rd_next = status_word(~TX_VALID, fifo_full, ovf,
                                              STATUS_COUNT_W'(fifo_count));
            SEL_CYCLE:  rd_next = cycle_cnt;
            SEL_CTRL:   rd_next = {31'b0, ie};
            default:    rd_next = UNMAPPED_DATA;
        endcase
    end

    // RAM contents survive reset; only writes outside reset land.
    always_ff @(posedge DM_CLK) begin
        if (!RST && DM_WE && sel == SEL_RAM) ram[ram_idx] <= DM_WR_DATA;
    end

    always_ff @(posedge DM_CLK) begin
        if (RST) begin
            DM_RD_DATA <= '0;
            cycle_cnt  <= '0;
            ovf        <= 1'b0;
            ie         <= 1'b0;
            IRQ        <= 1'b0;
        end else begin
            if (!DM_WE) DM_RD_DATA <= rd_next;
            cycle_cnt <= (DM_WE && sel == SEL_CYCLE) ? '0 : cycle_cnt + 32'd1;
            if (fifo_drop)
                ovf <= 1'b1;
            else if (DM_WE && sel == SEL_STATUS && DM_WR_DATA[STATUS_OVF])
                ovf <= 1'b0;
            ie  <= ie_next;
            // Interrupt tracks the state this edge leaves behind.
            IRQ <= ie_next & fifo_empty_next;
        end
    end

endmodule

// File: tb/tb_dm_subsys.sv
// Self-checking bench for dm_subsys: directed scenarios plus randomized
// traffic, all compared against a queue/array reference model.
module tb_dm_subsys;

    localparam int DEPTH = 8;

    logic        DM_CLK = 1'b0;
    logic        RST;
    logic        DM_WE;
    logic [31:0] DM_ADDR;
    logic [31:0] DM_WR_DATA;
    logic [31:0] DM_RD_DATA;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        IRQ;

    dm_subsys #(
        .RAM_WORDS (64),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .DM_CLK    (DM_CLK),
        .RST       (RST),
        .DM_WE     (DM_WE),
        .DM_ADDR   (DM_ADDR),
        .DM_WR_DATA(DM_WR_DATA),
        .DM_RD_DATA(DM_RD_DATA),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .TX_READY  (TX_READY),
        .IRQ       (IRQ)
    );

    // Clock / watchdog
    always #5 DM_CLK = ~DM_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model
    logic [31:0] m_ram [64];
    logic [7:0]  exp_q [$];
    logic        m_ovf;
    logic        m_ie;
    logic        m_irq;
    logic [31:0] m_cyc;
    logic [31:0] m_rd;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        int n;
        n = exp_q.size();
        return {23'b0, 5'(n), 1'b0, m_ovf, (n == DEPTH), (n == 0)};
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        logic [31:0] a;
        a = addr & 32'hFFFF_FFFC;
        if (a <= 32'h0FF) return m_ram[a[7:2]];
        case (a)
            32'h100: return 32'h0;
            32'h104: return m_status();
            32'h108: return m_cyc;
            32'h10C: return {31'b0, m_ie};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Advance the model across one clock edge using the current inputs.
    task automatic model_step();
        logic        popping;
        logic        was_full;
        logic [31:0] a;
        if (RST) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_ie  = 1'b0;
            m_cyc = 32'h0;
            m_rd  = 32'h0;
            m_irq = 1'b0;
            return;
        end
        popping  = (exp_q.size() != 0) && TX_READY;
        was_full = (exp_q.size() == DEPTH);
        a        = DM_ADDR & 32'hFFFF_FFFC;
        if (!DM_WE) m_rd = m_read(DM_ADDR);
        if (popping) void'(exp_q.pop_front());
        m_cyc = m_cyc + 32'd1;
        if (DM_WE) begin
            if (a <= 32'h0FF) m_ram[a[7:2]] = DM_WR_DATA;
            else if (a == 32'h100) begin
                if (was_full && !popping) m_ovf = 1'b1;
                else exp_q.push_back(DM_WR_DATA[7:0]);
            end
            else if (a == 32'h104) begin
                if (DM_WR_DATA[2]) m_ovf = 1'b0;
            end
            else if (a == 32'h108) m_cyc = 32'h0;
            else if (a == 32'h10C) m_ie = DM_WR_DATA[0];
        end
        m_irq = m_ie && (exp_q.size() == 0);
    endtask

    task automatic tick();
        logic [7:0] head;
        model_step();
        @(posedge DM_CLK);
        #1;
        head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        check("rd_data",  DM_RD_DATA, m_rd);
        check("tx_valid", {31'b0, TX_VALID}, {31'b0, (exp_q.size() != 0)});
        check("tx_data",  {24'b0, TX_DATA}, {24'b0, head});
        check("irq",      {31'b0, IRQ}, {31'b0, m_irq});
    endtask

    // Driver tasks
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        DM_WE      = 1'b1;
        DM_ADDR    = a;
        DM_WR_DATA = d;
        tick();
        DM_WE      = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        DM_WE   = 1'b0;
        DM_ADDR = a;
        tick();
    endtask

    task automatic idle();
        DM_WE   = 1'b0;
        DM_ADDR = 32'h200;
        tick();
    endtask

    initial begin
        RST        = 1'b1;
        DM_WE      = 1'b0;
        DM_ADDR    = 32'h0;
        DM_WR_DATA = 32'h0;
        TX_READY   = 1'b0;
        m_ovf = 1'b0; m_ie = 1'b0; m_irq = 1'b0; m_cyc = 32'h0; m_rd = 32'h0;

        // Reset and reset-state reads
        tick();
        tick();
        RST = 1'b0;
        do_read(32'h104);
        check("status_after_reset", DM_RD_DATA, 32'h0000_0001);
        do_read(32'h10C);
        check("ctrl_after_reset", DM_RD_DATA, 32'h0000_0000);
        do_read(32'h200);
        check("unmapped_read", DM_RD_DATA, 32'hFFFF_FFFF);

        // Fill RAM so every word has a known value
        for (int i = 0; i < 64; i++) do_write(32'(i * 4), $urandom());

        // RAM write/read and ignored unmapped write
        do_write(32'h004, 32'hDEAD_BEEF);
        do_read(32'h004);
        check("ram_read_004", DM_RD_DATA, 32'hDEAD_BEEF);
        do_read(32'h005);
        check("ram_read_005", DM_RD_DATA, 32'hDEAD_BEEF);
        do_write(32'h300, 32'h1234_5678);
        do_read(32'h300);
        check("unmapped_after_write", DM_RD_DATA, 32'hFFFF_FFFF);
        do_read(32'h004);
        check("ram_kept_004", DM_RD_DATA, 32'hDEAD_BEEF);

        // Overflow: nine pushes into an 8-deep FIFO with the consumer stalled
        TX_READY = 1'b0;
        for (int b = 1; b <= 9; b++) do_write(32'h100, 32'(b));
        do_read(32'h104);
        check("status_full_ovf", DM_RD_DATA, 32'h0000_0086);
        TX_READY = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("drain_order", {24'b0, TX_DATA}, 32'(k + 1));
            idle();
        end
        TX_READY = 1'b0;
        do_write(32'h104, 32'h4);
        do_read(32'h104);
        check("ovf_cleared", DM_RD_DATA, 32'h0000_0001);

        // Push and pop together while full
        for (int i = 0; i < 8; i++) do_write(32'h100, 32'h10 + 32'(i));
        TX_READY = 1'b1;
        do_write(32'h100, 32'hAA);
        TX_READY = 1'b0;
        do_read(32'h104);
        check("status_full_no_ovf", DM_RD_DATA, 32'h0000_0082);
        TX_READY = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("drain_push_pop", {24'b0, TX_DATA}, (k < 7) ? 32'h11 + 32'(k) : 32'hAA);
            idle();
        end
        TX_READY = 1'b0;

        // Interrupt behaviour
        do_write(32'h10C, 32'h1);
        check("irq_set", {31'b0, IRQ}, 32'h1);
        do_write(32'h100, 32'h55);
        check("irq_drop_on_push", {31'b0, IRQ}, 32'h0);
        do_write(32'h100, 32'h66);
        TX_READY = 1'b1;
        idle();
        check("irq_low_one_left", {31'b0, IRQ}, 32'h0);
        idle();
        check("irq_after_last_pop", {31'b0, IRQ}, 32'h1);
        TX_READY = 1'b0;

        // Cycle counter clear, count and wrap
        do_write(32'h108, 32'h1234);
        repeat (5) idle();
        do_read(32'h108);
        check("cycle_after_5", DM_RD_DATA, 32'd5);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        m_cyc = 32'hFFFF_FFFF;
        do_read(32'h108);
        check("cycle_preload", DM_RD_DATA, 32'hFFFF_FFFF);
        do_read(32'h108);
        check("cycle_wrap", DM_RD_DATA, 32'h0);

        // Reset mid-transfer with three bytes queued
        for (int i = 0; i < 3; i++) do_write(32'h100, 32'hC1 + 32'(i));
        RST        = 1'b1;
        DM_WE      = 1'b1;
        DM_ADDR    = 32'h100;
        DM_WR_DATA = 32'hEE;
        TX_READY   = 1'b1;
        tick();
        RST      = 1'b0;
        DM_WE    = 1'b0;
        TX_READY = 1'b0;
        check("valid_after_rst", {31'b0, TX_VALID}, 32'h0);
        do_read(32'h104);
        check("status_after_rst", DM_RD_DATA, 32'h0000_0001);
        do_read(32'h004);
        check("ram_survives_rst", DM_RD_DATA, 32'hDEAD_BEEF);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            RST        = ($urandom_range(0, 63) == 0);
            TX_READY   = 1'($urandom_range(0, 1));
            DM_WE      = 1'($urandom_range(0, 1));
            DM_WR_DATA = $urandom();
            case ($urandom_range(0, 7))
                0, 1:    DM_ADDR = 32'($urandom_range(0, 255));
                2, 3:    DM_ADDR = 32'h100 | 32'($urandom_range(0, 3));
                4:       DM_ADDR = 32'h104 | 32'($urandom_range(0, 3));
                5:       DM_ADDR = 32'h108 | 32'($urandom_range(0, 3));
                6:       DM_ADDR = 32'h10C | 32'($urandom_range(0, 3));
                default: DM_ADDR = $urandom();
            endcase
            tick();
        end
        RST   = 1'b0;
        DM_WE = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
